// File: rtl/if_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_queue
//   Fetch stage between the PC unit and decode. Each accepted instruction
//   memory request reserves a ring slot tagged with its PC and PC+4. In-order
//   responses fill the slots, and decode drains the head over valid/ready as
//   {instr, pc, pc+4}. A flush discards every queued entry. It also arranges
//   for the responses still in flight to be thrown away when they arrive.
//
//   Optional feature: define FETCH_PERF_EN to add the fetch_cnt / flush_cnt
//   performance counters. With the macro undefined these ports are absent.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous reset, active low
//   pc_i            current PC from the PC unit
//   pc_plus_4_i     current PC+4 from the PC unit
//   pc_advance      PC unit may step (request accepted this cycle)
//   flush           redirect taken: kill queued and in-flight fetches
//   imem_req_valid  request valid, address is pc_i
//   imem_req_addr   request address
//   imem_req_ready  memory accepts request
//   imem_rsp_valid  in-order response valid
//   imem_rsp_data   instruction word
//   id_valid        head slot holds a filled instruction
//   id_ready        decode accepts head
//   id_instr        head instruction
//   id_pc           head PC
//   id_pc_plus_4    head PC+4
//   fetch_cnt       (FETCH_PERF_EN) dequeues to decode, wrapping
//   flush_cnt       (FETCH_PERF_EN) flush cycles, wrapping
// -----------------------------------------------------------------------------
module if_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_i,
    input  logic [AW-1:0] pc_plus_4_i,
    output logic          pc_advance,
    input  logic          flush,
    output logic          imem_req_valid,
    output logic [AW-1:0] imem_req_addr,
    input  logic          imem_req_ready,
    input  logic          imem_rsp_valid,
    input  logic [31:0]   imem_rsp_data,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [31:0]   id_instr,
    output logic [AW-1:0] id_pc,
    output logic [AW-1:0] id_pc_plus_4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   fetch_cnt,
    output logic [31:0]   flush_cnt
`endif
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    logic [PW-1:0] alloc_q, alloc_d;
    logic [PW-1:0] fill_q,  fill_d;
    logic [PW-1:0] head_q,  head_d;
    logic [PW-1:0] drop_q,  drop_d;

    logic [PW-1:0] occ;
    logic [PW-1:0] inflight;
    logic          ring_full;
    logic          drop_active;
    logic          issue_ok;
    logic          issue_fire;
    logic          rsp_counted;
    logic          rsp_keep;
    logic          rsp_drop;
    logic          head_valid;
    logic          deq_fire;

    logic [AW-1:0] ring_pc    [DEPTH];
    logic [AW-1:0] ring_pc4   [DEPTH];
    logic [31:0]   ring_instr [DEPTH];

    logic [IW-1:0] alloc_idx;
    logic [IW-1:0] fill_idx;
    logic [IW-1:0] head_idx;

    assign alloc_idx = alloc_q[IW-1:0];
    assign fill_idx  = fill_q[IW-1:0];
    assign head_idx  = head_q[IW-1:0];

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the block
        // can leave a value unassigned and infer a latch.
        occ         = alloc_q - head_q;
        inflight    = alloc_q - fill_q;
        ring_full   = (occ == DEPTH_P);
        drop_active = (drop_q != '0);

        // The reset term is applied on the outputs only. While reset is held,
        // the pointer flops are already pinned at zero.
        issue_ok    = !flush && !ring_full && !drop_active;
        issue_fire  = issue_ok && imem_req_ready;

        // A response is honoured only if something is actually owed to us.
        rsp_counted = imem_rsp_valid && (drop_active || (inflight != '0));
        rsp_keep    = rsp_counted && !drop_active && !flush;
        rsp_drop    = rsp_counted && drop_active;

        head_valid  = (head_q != fill_q) && !flush;
        deq_fire    = head_valid && id_ready;

        alloc_d = alloc_q;
        fill_d  = fill_q;
        head_d  = head_q;
        drop_d  = drop_q;

        if (flush) begin
            alloc_d = '0;
            fill_d  = '0;
            head_d  = '0;
            // Every response still owed to the ring becomes one to discard.
            // A response arriving in this cycle is already gone.
            // drop_q is added in because a back-to-back flush can land while
            // earlier drops are still pending. inflight is zero in that case.
            drop_d  = drop_q + inflight - PW'(rsp_counted);
        end else begin
            alloc_d = alloc_q + PW'(issue_fire);
            fill_d  = fill_q  + PW'(rsp_keep);
            head_d  = head_q  + PW'(deq_fire);
            drop_d  = drop_q  - PW'(rsp_drop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alloc_q <= '0;
            fill_q  <= '0;
            head_q  <= '0;
            drop_q  <= '0;
        end else begin
            alloc_q <= alloc_d;
            fill_q  <= fill_d;
            head_q  <= head_d;
            drop_q  <= drop_d;
        end
    end

    // NOTE: the ring storage has no reset. A slot is only ever read after its
    // own write, so clearing it would buy nothing and block RAM inference.
    always_ff @(posedge clk) begin
        if (issue_fire) begin
            ring_pc[alloc_idx]  <= pc_i;
            ring_pc4[alloc_idx] <= pc_plus_4_i;
        end
        if (rsp_keep) begin
            ring_instr[fill_idx] <= imem_rsp_data;
        end
    end

    assign imem_req_valid = rst && issue_ok;
    assign imem_req_addr  = pc_i;
    assign pc_advance     = rst && issue_fire;

    assign id_valid       = head_valid;
    assign id_instr       = ring_instr[head_idx];
    assign id_pc          = ring_pc[head_idx];
    assign id_pc_plus_4   = ring_pc4[head_idx];

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 32'(deq_fire);
        flush_cnt_d = flush_cnt_q + 32'(flush);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
